// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM encoding,
// register-zero constant and the per-latch {en, clr_n} control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic en;
    logic clr_n;
  } latch_ctrl_t;

  localparam latch_ctrl_t LC_PASS  = '{en: 1'b1, clr_n: 1'b1};
  localparam latch_ctrl_t LC_HOLD  = '{en: 1'b0, clr_n: 1'b1};
  localparam latch_ctrl_t LC_KILL  = '{en: 1'b1, clr_n: 1'b0};
  localparam latch_ctrl_t LC_RESET = '{en: 1'b0, clr_n: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the ID/EX/MEM stages and the latch/PC controls back to them.
interface pipeline_ctrl_if #(
  parameter int COUNT_W = 16
);
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               id_uses_rt;
  logic               ex_mem_read;
  logic [4:0]         ex_rw;
  logic               branch_taken;
  logic               dmem_req;
  logic               dmem_ack;

  logic               pc_en;
  logic               if_id_en;
  logic               id_ex_en;
  logic               ex_mem_en;
  logic               mem_wb_en;
  logic               if_id_clr_n;
  logic               id_ex_clr_n;
  logic               ex_mem_clr_n;
  logic               mem_wb_clr_n;
  logic [COUNT_W-1:0] stall_count;
  logic               mem_error;
  logic [1:0]         state;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rw,
           branch_taken, dmem_req, dmem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_clr_n, id_ex_clr_n, ex_mem_clr_n, mem_wb_clr_n,
           stall_count, mem_error, state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rw,
           branch_taken, dmem_req, dmem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_clr_n, id_ex_clr_n, ex_mem_clr_n, mem_wb_clr_n,
           stall_count, mem_error, state
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the ID instruction.
// Purely combinational; r0 never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rw,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       lu
);

  always_comb begin
    lu = ex_mem_read && (ex_rw != REG_ZERO) &&
         ((ex_rw == id_rs) || (id_uses_rt && (ex_rw == id_rt)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline: Mealy latch/PC controls,
// memory-wait FSM with watchdog, and a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int COUNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.slave   bus
);
  import pipe_ctrl_pkg::*;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] cnt_q;

  logic        lu;
  logic        ms;
  logic        mem_stall;
  logic        pc_en;
  logic        cnt_en;
  latch_ctrl_t if_id, id_ex, ex_mem, mem_wb;

  hazard_detect u_hazard (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rw       (bus.ex_rw),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .lu          (lu)
  );

  assign ms = bus.dmem_req && !bus.dmem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (ms) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end else begin
          wait_d  = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ack) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) begin
            state_d = HALT;
            err_d   = 1'b1;
          end
        end
      end
      HALT: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = HALT;
        err_d   = 1'b1;
      end
    endcase
  end

  // In MEM_WAIT only the ack ends the stall; a held request does not re-arm it.
  always_comb begin
    pc_en     = 1'b1;
    if_id     = LC_PASS;
    id_ex     = LC_PASS;
    ex_mem    = LC_PASS;
    mem_wb    = LC_PASS;
    mem_stall = 1'b0;
    case (state_q)
      RUN:      mem_stall = ms;
      MEM_WAIT: mem_stall = !bus.dmem_ack;
      default:  mem_stall = 1'b0;
    endcase

    if (reset) begin
      pc_en  = 1'b0;
      if_id  = LC_RESET;
      id_ex  = LC_RESET;
      ex_mem = LC_RESET;
      mem_wb = LC_RESET;
    end else if (state_q == HALT || state_q == ILLEGAL) begin
      pc_en  = 1'b0;
      if_id  = LC_HOLD;
      id_ex  = LC_HOLD;
      ex_mem = LC_HOLD;
      mem_wb = LC_HOLD;
    end else if (mem_stall) begin
      pc_en  = 1'b0;
      if_id  = LC_HOLD;
      id_ex  = LC_HOLD;
      ex_mem = LC_HOLD;
      mem_wb = LC_KILL;
    end else if (bus.branch_taken) begin
      if_id  = LC_KILL;
      id_ex  = LC_KILL;
    end else if (lu) begin
      pc_en  = 1'b0;
      if_id  = LC_HOLD;
      id_ex  = LC_KILL;
    end
  end

  assign cnt_en = !reset && !pc_en && (state_q == RUN || state_q == MEM_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id.en;
  assign bus.id_ex_en     = id_ex.en;
  assign bus.ex_mem_en    = ex_mem.en;
  assign bus.mem_wb_en    = mem_wb.en;
  assign bus.if_id_clr_n  = if_id.clr_n;
  assign bus.id_ex_clr_n  = id_ex.clr_n;
  assign bus.ex_mem_clr_n = ex_mem.clr_n;
  assign bus.mem_wb_clr_n = mem_wb.clr_n;
  assign bus.stall_count  = reset ? '0 : cnt_q;
  assign bus.mem_error    = err_q && !reset;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (TIMEOUT=4, COUNT_W=4) with hand-computed expectations.
module tb_pipeline_ctrl;

  logic clk;
  logic reset;

  pipeline_ctrl_if #(.COUNT_W(4)) bus ();

  pipeline_ctrl #(.TIMEOUT(4), .COUNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr_n, id_ex_clr_n, ex_mem_clr_n, mem_wb_clr_n}
  logic [8:0] ctl;
  assign ctl = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_clr_n, bus.id_ex_clr_n, bus.ex_mem_clr_n, bus.mem_wb_clr_n};

  localparam logic [8:0] CTL_RESET  = 9'b0_0000_0000;
  localparam logic [8:0] CTL_RUN    = 9'b1_1111_1111;
  localparam logic [8:0] CTL_LU     = 9'b0_0111_1011;
  localparam logic [8:0] CTL_BRANCH = 9'b1_1111_0011;
  localparam logic [8:0] CTL_MEM    = 9'b0_0001_1110;
  localparam logic [8:0] CTL_HALT   = 9'b0_0000_1111;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs        = 5'd0;
    bus.id_rt        = 5'd0;
    bus.id_uses_rt   = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_rw        = 5'd0;
    bus.branch_taken = 1'b0;
    bus.dmem_req     = 1'b0;
    bus.dmem_ack     = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset held for two cycles
    tick();
    tick();
    chk("rst_ctl", 32'(ctl), 32'(CTL_RESET));
    chk("rst_cnt", 32'(bus.stall_count), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_err", 32'(bus.mem_error), 32'd0);
    reset = 1'b0;
    #1;
    chk("run_ctl", 32'(ctl), 32'(CTL_RUN));

    // Load-use on rs
    bus.ex_mem_read = 1'b1; bus.ex_rw = 5'd5; bus.id_rs = 5'd5;
    #1;
    chk("lu_rs_ctl", 32'(ctl), 32'(CTL_LU));
    tick();
    chk("lu_rs_cnt", 32'(bus.stall_count), 32'd1);

    // Load to r0 never stalls
    bus.ex_rw = 5'd0; bus.id_rs = 5'd0;
    #1;
    chk("lu_r0_ctl", 32'(ctl), 32'(CTL_RUN));
    tick();
    chk("lu_r0_cnt", 32'(bus.stall_count), 32'd1);

    // rt match only counts when rt is read
    bus.ex_rw = 5'd7; bus.id_rs = 5'd3; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b0;
    #1;
    chk("lu_rt_unused", 32'(ctl), 32'(CTL_RUN));
    tick();
    bus.id_uses_rt = 1'b1;
    #1;
    chk("lu_rt_ctl", 32'(ctl), 32'(CTL_LU));
    tick();
    chk("lu_rt_cnt", 32'(bus.stall_count), 32'd2);

    // Branch wins over a simultaneous load-use
    bus.branch_taken = 1'b1;
    #1;
    chk("br_ctl", 32'(ctl), 32'(CTL_BRANCH));
    tick();
    chk("br_cnt", 32'(bus.stall_count), 32'd2);
    idle_inputs();

    // Memory access acked three cycles after the request; branch held until ack
    bus.dmem_req = 1'b1;
    #1;
    chk("mw0_ctl", 32'(ctl), 32'(CTL_MEM));
    chk("mw0_state", 32'(bus.state), 32'd0);
    tick();
    chk("mw1_state", 32'(bus.state), 32'd1);
    chk("mw1_ctl", 32'(ctl), 32'(CTL_MEM));
    tick();
    bus.branch_taken = 1'b1;
    #1;
    chk("mw2_state", 32'(bus.state), 32'd1);
    chk("mw2_br_ctl", 32'(ctl), 32'(CTL_MEM));
    tick();
    bus.dmem_ack = 1'b1;
    #1;
    chk("mw3_state", 32'(bus.state), 32'd1);
    chk("mw3_ack_ctl", 32'(ctl), 32'(CTL_BRANCH));
    tick();
    chk("mw_done_state", 32'(bus.state), 32'd0);
    chk("mw_done_cnt", 32'(bus.stall_count), 32'd5);

    // Ack in the same cycle as the request
    bus.branch_taken = 1'b0;
    bus.dmem_req = 1'b1; bus.dmem_ack = 1'b1;
    #1;
    chk("fast_ack_ctl", 32'(ctl), 32'(CTL_RUN));
    tick();
    chk("fast_ack_state", 32'(bus.state), 32'd0);
    chk("fast_ack_cnt", 32'(bus.stall_count), 32'd5);
    idle_inputs();

    // Reset in the middle of a memory wait
    bus.dmem_req = 1'b1;
    tick();
    chk("mid_wait_state", 32'(bus.state), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("mid_rst_state", 32'(bus.state), 32'd0);
    chk("mid_rst_cnt", 32'(bus.stall_count), 32'd0);

    // Watchdog: no ack, HALT after three MEM_WAIT cycles
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wd_state%0d", i), 32'(bus.state), (i == 0) ? 32'd0 : 32'd1);
      chk($sformatf("wd_err%0d", i), 32'(bus.mem_error), 32'd0);
      tick();
    end
    chk("halt_state", 32'(bus.state), 32'd2);
    chk("halt_err", 32'(bus.mem_error), 32'd1);
    chk("halt_ctl", 32'(ctl), 32'(CTL_HALT));
    chk("halt_cnt", 32'(bus.stall_count), 32'd4);
    bus.dmem_ack = 1'b1;
    #1;
    chk("late_ack_ctl", 32'(ctl), 32'(CTL_HALT));
    tick();
    chk("late_ack_state", 32'(bus.state), 32'd2);
    chk("late_ack_cnt", 32'(bus.stall_count), 32'd4);
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    #1;
    chk("clr_err", 32'(bus.mem_error), 32'd0);
    chk("clr_state", 32'(bus.state), 32'd0);

    // Saturation: 20 load-use cycles into a 4-bit counter
    bus.ex_mem_read = 1'b1; bus.ex_rw = 5'd9; bus.id_rs = 5'd9;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 32'(bus.stall_count), 32'd15);
    idle_inputs();
    tick();
    chk("sat_hold", 32'(bus.stall_count), 32'd15);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
